// File: rtl/spi_pkg.sv
// Shared SPI datapath definitions: FSM encoding, counter width helper, bit-order constants.
package spi_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam bit MSB_FIRST = 1'b0;
  localparam bit LSB_FIRST = 1'b1;

  // Width of a counter holding 0..data_w-1 (data_w >= 2).
  function automatic int unsigned cnt_w(input int unsigned data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register for completed words, with overrun detection.
module sipo_out_buf #(
  parameter int unsigned DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              out_ready,
  input  logic              clr_ovr,
  output logic [DATA_W-1:0] parallel_data,
  output logic              data_valid,
  output logic              overrun,
  output logic              overrun_sticky
);

  logic drop_c;

  // A completed word is dropped only when an unaccepted word is still held.
  assign drop_c = load && data_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parallel_data  <= '0;
      data_valid     <= 1'b0;
      overrun        <= 1'b0;
      overrun_sticky <= 1'b0;
    end else begin
      overrun <= drop_c;
      if (load) begin
        if (!drop_c) begin
          parallel_data <= word;
          data_valid    <= 1'b1;
        end
      end else if (out_ready) begin
        data_valid <= 1'b0;
      end
      // A new overrun beats a simultaneous clear.
      if (drop_c) begin
        overrun_sticky <= 1'b1;
      end else if (clr_ovr) begin
        overrun_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_sipo_deser.sv
// SPI slave serial-to-parallel deserializer: bit FSM, counter and shift register
// feeding a one-entry valid/ready output buffer.
module spi_sipo_deser
  import spi_pkg::*;
#(
  parameter int unsigned  DATA_W       = 10,
  parameter bit           LSB_FIRST    = 1'b0,
  parameter bit           HOLD_ON_IDLE = 1'b0,
  localparam int unsigned CNT_W        = cnt_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              serial_in,
  input  logic              out_ready,
  input  logic              clr_ovr,
  output logic [DATA_W-1:0] parallel_data,
  output logic              data_valid,
  output logic [CNT_W-1:0]  bit_count,
  output logic              overrun,
  output logic              overrun_sticky,
  output logic              frame_abort
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_e            state, state_nxt;
  logic [DATA_W-1:0] sr, sr_nxt, sr_shift_c;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              abort_nxt;
  logic              load_c;

  // Shift register advanced by one bit; on the last bit this is the completed word.
  always_comb begin
    if (LSB_FIRST == spi_pkg::LSB_FIRST) begin
      sr_shift_c = {serial_in, sr[DATA_W-1:1]};
    end else begin
      sr_shift_c = {sr[DATA_W-2:0], serial_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sr          <= '0;
      bit_count   <= '0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      sr          <= sr_nxt;
      bit_count   <= cnt_nxt;
      frame_abort <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = bit_count;
    abort_nxt = 1'b0;
    load_c    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          sr_nxt    = sr_shift_c;
          cnt_nxt   = CNT_W'(1);
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (enable) begin
          if (bit_count == LAST_BIT) begin
            load_c    = 1'b1;
            sr_nxt    = '0;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            sr_nxt  = sr_shift_c;
            cnt_nxt = bit_count + CNT_W'(1);
          end
        end else if (!HOLD_ON_IDLE) begin
          sr_nxt    = '0;
          cnt_nxt   = '0;
          abort_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sipo_out_buf #(
    .DATA_W(DATA_W)
  ) u_out_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load_c),
    .word          (sr_shift_c),
    .out_ready     (out_ready),
    .clr_ovr       (clr_ovr),
    .parallel_data (parallel_data),
    .data_valid    (data_valid),
    .overrun       (overrun),
    .overrun_sticky(overrun_sticky)
  );

endmodule

// File: tb/tb_spi_sipo_deser.sv
// Bench for spi_sipo_deser: three configurations (MSB-first, LSB-first, hold-on-idle)
// driven by shared stimulus and checked every cycle against a bit-list model.
module tb_spi_sipo_deser;

  localparam int unsigned W = 10;

  logic clk;
  logic rst_n, enable, serial_in, out_ready, clr_ovr;
  logic [W-1:0] pd [3];
  logic [3:0]   bc [3];
  logic         dv [3], ovr [3], stk [3], fa [3];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: bits of the current frame in arrival order, plus output-side state.
  int           m_nb   [3];
  logic [W-1:0] m_bits [3];
  logic [W-1:0] m_data [3];
  logic         m_valid [3], m_ovr [3], m_stk [3], m_fa [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_sipo_deser #(.DATA_W(W), .LSB_FIRST(1'b0), .HOLD_ON_IDLE(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .serial_in(serial_in),
    .out_ready(out_ready), .clr_ovr(clr_ovr), .parallel_data(pd[0]),
    .data_valid(dv[0]), .bit_count(bc[0]), .overrun(ovr[0]),
    .overrun_sticky(stk[0]), .frame_abort(fa[0]));

  spi_sipo_deser #(.DATA_W(W), .LSB_FIRST(1'b1), .HOLD_ON_IDLE(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .serial_in(serial_in),
    .out_ready(out_ready), .clr_ovr(clr_ovr), .parallel_data(pd[1]),
    .data_valid(dv[1]), .bit_count(bc[1]), .overrun(ovr[1]),
    .overrun_sticky(stk[1]), .frame_abort(fa[1]));

  spi_sipo_deser #(.DATA_W(W), .LSB_FIRST(1'b0), .HOLD_ON_IDLE(1'b1)) u_hold (
    .clk(clk), .rst_n(rst_n), .enable(enable), .serial_in(serial_in),
    .out_ready(out_ready), .clr_ovr(clr_ovr), .parallel_data(pd[2]),
    .data_valid(dv[2]), .bit_count(bc[2]), .overrun(ovr[2]),
    .overrun_sticky(stk[2]), .frame_abort(fa[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      logic [W-1:0] word;
      bit done;
      word = '0;
      done = 1'b0;
      if (!rst_n) begin
        m_nb[k] = 0; m_bits[k] = '0; m_data[k] = '0;
        m_valid[k] = 1'b0; m_ovr[k] = 1'b0; m_stk[k] = 1'b0; m_fa[k] = 1'b0;
      end else begin
        m_ovr[k] = 1'b0;
        m_fa[k]  = 1'b0;
        if (enable) begin
          m_bits[k][m_nb[k]] = serial_in;
          m_nb[k]++;
          if (m_nb[k] == int'(W)) begin
            for (int i = 0; i < int'(W); i++) begin
              if (k == 1) word[i] = m_bits[k][i];
              else        word[int'(W) - 1 - i] = m_bits[k][i];
            end
            done = 1'b1;
            m_nb[k] = 0;
          end
        end else if (k != 2 && m_nb[k] > 0) begin
          m_fa[k] = 1'b1;
          m_nb[k] = 0;
        end
        if (done) begin
          if (!m_valid[k] || out_ready) begin
            m_data[k]  = word;
            m_valid[k] = 1'b1;
          end else begin
            m_ovr[k] = 1'b1;
          end
        end else if (out_ready) begin
          m_valid[k] = 1'b0;
        end
        if (m_ovr[k]) m_stk[k] = 1'b1;
        else if (clr_ovr) m_stk[k] = 1'b0;
      end
    end
  endtask

  // Every-cycle comparison of all three DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("pdata[%0d]", k), 32'(pd[k]), 32'(m_data[k]));
        chk($sformatf("valid[%0d]", k), 32'(dv[k]), 32'(m_valid[k]));
        chk($sformatf("bitcnt[%0d]", k), 32'(bc[k]), 32'(m_nb[k]));
        chk($sformatf("ovr[%0d]", k), 32'(ovr[k]), 32'(m_ovr[k]));
        chk($sformatf("sticky[%0d]", k), 32'(stk[k]), 32'(m_stk[k]));
        chk($sformatf("abort[%0d]", k), 32'(fa[k]), 32'(m_fa[k]));
      end
    end
  end

  task automatic cyc(input logic en, input logic s, input logic r, input logic c, input logic rs);
    enable = en; serial_in = s; out_ready = r; clr_ovr = c; rst_n = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic feed_word(input logic [W-1:0] w, input logic r);
    for (int j = 0; j < int'(W); j++) cyc(1'b1, w[int'(W) - 1 - j], r, 1'b0, 1'b1);
  endtask

  initial begin
    logic [W-1:0] stream;
    logic [W-1:0] w;
    int pulses, first_at, second_at, ovr_pulses;

    chk_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("reset_valid", 32'(dv[k]), 32'd0);
      chk("reset_data", 32'(pd[k]), 32'd0);
    end

    // Reference stream 1,1,0,0,1,1,0,1,0,1
    stream = 10'b1100110101;
    feed_word(stream, 1'b1);
    chk("msb_word", 32'(pd[0]), 32'h335);
    chk("msb_valid", 32'(dv[0]), 32'd1);
    chk("lsb_word", 32'(pd[1]), 32'h2B3);
    chk("model_msb", 32'(m_data[0]), 32'h335);
    chk("model_lsb", 32'(m_data[1]), 32'h2B3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("msb_valid_pulse", 32'(dv[0]), 32'd0);

    // Back-to-back frames
    pulses = 0; first_at = -1; second_at = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
      if (dv[0] === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i; else second_at = i;
      end
    end
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_first", 32'(first_at), 32'd9);
    chk("b2b_gap", 32'(second_at - first_at), 32'd10);

    // Overrun with consumer stalled
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    ovr_pulses = 0;
    feed_word(10'h3FF, 1'b0);
    for (int j = 0; j < 10; j++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (ovr[0] === 1'b1) ovr_pulses++;
    end
    chk("ovr_after_20", 32'(ovr[0]), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_pulses", 32'(ovr_pulses), 32'd1);
    chk("ovr_hold_word", 32'(pd[0]), 32'h3FF);
    chk("ovr_sticky", 32'(stk[0]), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("sticky_cleared", 32'(stk[0]), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Abort after 4 bits
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("abort_pulse", 32'(fa[0]), 32'd1);
    chk("abort_bitcnt", 32'(bc[0]), 32'd0);
    chk("hold_bitcnt", 32'(bc[2]), 32'd4);
    chk("hold_no_abort", 32'(fa[2]), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("hold_bitcnt_kept", 32'(bc[2]), 32'd4);
    w = 10'h1A5;
    for (int j = 0; j < int'(W); j++) begin
      cyc(1'b1, w[int'(W) - 1 - j], 1'b1, 1'b0, 1'b1);
      if (j == 5) begin
        chk("hold_valid", 32'(dv[2]), 32'd1);
        chk("hold_word", 32'(pd[2]), 32'h2DA);
      end
    end
    chk("clean_valid", 32'(dv[0]), 32'd1);
    chk("clean_word", 32'(pd[0]), 32'h1A5);

    // Reset mid-frame with a word pending
    feed_word(10'h3C6, 1'b0);
    for (int j = 0; j < 5; j++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("rst_data", 32'(pd[k]), 32'd0);
      chk("rst_valid", 32'(dv[k]), 32'd0);
      chk("rst_bitcnt", 32'(bc[k]), 32'd0);
      chk("rst_sticky", 32'(stk[k]), 32'd0);
    end
    feed_word(10'h0F3, 1'b1);
    chk("post_rst_msb", 32'(pd[0]), 32'h0F3);
    chk("post_rst_lsb", 32'(pd[1]), 32'h33C);
    chk("post_rst_hold", 32'(pd[2]), 32'h0F3);
    chk("post_rst_valid", 32'(dv[0]), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 4) < 3), 1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 199) != 0));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
